// File: rtl/mul_pkg.sv
// Shared M-extension decode constants and multiplier FSM state type.
package mul_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;

    // Bit 2 of funct3 does not affect the multiply operations.
    localparam logic [2:0] F3_MUL_MASK = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_iterative_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU; one product bit per cycle.
module mul_iterative_unit
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              stall
);

    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned PROD_W = 2 * DATA_W;

    mul_state_t r_state;
    mul_state_t w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_result;
    logic              r_neg;
    logic              r_hi_sel;
    logic              r_done;

    logic [2:0]        w_f3;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_last;
    logic [PROD_W-1:0] w_acc_nxt;
    logic [PROD_W-1:0] w_prod;

    assign w_f3    = funct3 & F3_MUL_MASK;
    assign w_a_neg = ((w_f3 == MULH_F3) || (w_f3 == MULHSU_F3)) && op_a[DATA_W-1];
    assign w_b_neg = (w_f3 == MULH_F3) && op_b[DATA_W-1];
    // Magnitude of the most negative value wraps to itself, which is correct unsigned.
    assign w_a_mag = w_a_neg ? -op_a : op_a;
    assign w_b_mag = w_b_neg ? -op_b : op_b;

    assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                stall = start;
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                stall = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_hi_sel <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_hi_sel <= (w_f3 != MUL_F3);
            end else if (r_state == RUN) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                // Final partial product is folded in so result is valid during DONE.
                if (w_last) begin
                    r_done   <= 1'b1;
                    r_result <= r_hi_sel ? w_prod[PROD_W-1:DATA_W] : w_prod[DATA_W-1:0];
                end
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mul_iterative_unit.sv
// Directed-vector bench for mul_iterative_unit: latency, stall, results, start hold, reset abort.
module tb_mul_iterative_unit;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    mul_iterative_unit #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start in cycle 0, drop start and scramble inputs in cycle 1, expect done in cycle 33.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int unsigned early_done = 0;
        int unsigned stall_low  = 0;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1 chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; funct3 = 3'b111; op_a = 32'h5A5A_1234; op_b = 32'hDEAD_BEEF;
            end
            if (cyc < 33) begin
                if (done)   early_done++;
                if (!stall) stall_low++;
            end else begin
                chk({tag, "_early_done"}, early_done, 32'd0);
                chk({tag, "_stall_run"},  stall_low,  32'd0);
                chk({tag, "_done"},   32'(done),  32'd1);
                chk({tag, "_stall_done"}, 32'(stall), 32'd0);
                chk({tag, "_result"}, result, exp);
            end
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_held"},      result,    exp);
    endtask

    initial begin
        int unsigned n_done;
        int unsigned wait_cyc;
        bit          got_done;

        rst = 1'b1; start = 1'b0; funct3 = MUL_F3; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_result", result,     32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        rst = 1'b0;

        run_op("mul_7x6",     MUL_F3,    32'd7,         32'd6,         32'h0000_002A);
        run_op("mulh_m1m1",   MULH_F3,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu_m1m1",  MULHU_F3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_m2x3", MULHSU_F3, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
        run_op("mul_m2x3",    MUL_F3,    32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA);
        run_op("mulh_min",    MULH_F3,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mul_min",     MUL_F3,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("mulhu_f3b2",  3'b111,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // start held high through DONE: one pulse, then re-accept in cycle 34.
        n_done = 0;
        @(negedge clk);
        funct3 = MUL_F3; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (done) n_done++;
            if (cyc == 33) chk("hold_result", result, 32'h0000_0051);
            if (cyc == 34) begin
                chk("hold_c34_busy", 32'(busy), 32'd0);
                funct3 = MULHU_F3; op_a = 32'h0001_0000; op_b = 32'h0001_0000;
                #1 chk("hold_c34_stall", 32'(stall), 32'd1);
            end
        end
        chk("hold_one_done", n_done, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_rerun_busy", 32'(busy), 32'd1);
        got_done = 1'b0;
        wait_cyc = 1;
        while (!got_done && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
            if (done) got_done = 1'b1;
        end
        chk("hold_rerun_latency", wait_cyc, 32'd33);
        chk("hold_rerun_result",  result,   32'h0000_0001);

        // Reset in cycle 10 of a run aborts it.
        @(negedge clk);
        funct3 = MUL_F3; op_a = 32'd100; op_b = 32'd100; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   32'(busy),  32'd0);
        chk("abort_done",   32'(done),  32'd0);
        chk("abort_result", result,     32'd0);
        chk("abort_stall0", 32'(stall), 32'd0);
        start = 1'b1;
        #1 chk("abort_stall1", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_3x5_post_rst", MUL_F3, 32'd3, 32'd5, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
